dct_transpose_buffer: RTL and testbench

Ping-pong 8x8 transpose memory between the row 1-D DCT and the column 1-D DCT of the 2-D DCT pipeline. It accepts one 8-coefficient row per beat from the row DCT (natural order, coefficient 0..7) and presents the stored block column by column to the column DCT. Two banks let block N+1 be written while block N is read. A stall input from the consumer allows back-pressure; rows arriving with no free bank are dropped and flagged.

---
 rtl/dct_transpose_buffer_if.sv | 55 +++++
 rtl/dct_transpose_buffer.sv | 135 +++++++++++++
 tb/tb_dct_transpose_buffer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/dct_transpose_buffer_if.sv
// Row-in / column-out bus of the 8x8 DCT transpose buffer.
// The master drives rows and the column-accept signal; the slave is the buffer.
interface dct_transpose_buffer_if #(
    parameter int DATA_W = 14
);
    logic              i_valid;
    logic [DATA_W-1:0] i_data0;
    logic [DATA_W-1:0] i_data1;
    logic [DATA_W-1:0] i_data2;
    logic [DATA_W-1:0] i_data3;
    logic [DATA_W-1:0] i_data4;
    logic [DATA_W-1:0] i_data5;
    logic [DATA_W-1:0] i_data6;
    logic [DATA_W-1:0] i_data7;
    logic              i_ready;

    logic              o_valid;
    logic [DATA_W-1:0] o_data0;
    logic [DATA_W-1:0] o_data1;
    logic [DATA_W-1:0] o_data2;
    logic [DATA_W-1:0] o_data3;
    logic [DATA_W-1:0] o_data4;
    logic [DATA_W-1:0] o_data5;
    logic [DATA_W-1:0] o_data6;
    logic [DATA_W-1:0] o_data7;
    logic [2:0]        o_col_idx;
    logic              o_last;
    logic              o_overflow;

    modport master (
        output i_valid,
        output i_data0, i_data1, i_data2, i_data3,
        output i_data4, i_data5, i_data6, i_data7,
        output i_ready,
        input  o_valid,
        input  o_data0, o_data1, o_data2, o_data3,
        input  o_data4, o_data5, o_data6, o_data7,
        input  o_col_idx,
        input  o_last,
        input  o_overflow
    );

    modport slave (
        input  i_valid,
        input  i_data0, i_data1, i_data2, i_data3,
        input  i_data4, i_data5, i_data6, i_data7,
        input  i_ready,
        output o_valid,
        output o_data0, o_data1, o_data2, o_data3,
        output o_data4, o_data5, o_data6, o_data7,
        output o_col_idx,
        output o_last,
        output o_overflow
    );
endinterface

// File: rtl/dct_transpose_buffer.sv
// Ping-pong 8x8 transpose memory between the row and column 1-D DCTs.
// Rows are written into one bank while the other bank is read out column by column.
module dct_transpose_buffer #(
    parameter int DATA_W = 14
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    dct_transpose_buffer_if.slave bus
);

    logic [DATA_W-1:0] mem [2][8][8];

    logic       wr_bank;
    logic [2:0] wr_row;
    logic       rd_bank;
    logic [2:0] rd_col;
    logic [1:0] full;
    logic       overflow;

    logic [DATA_W-1:0] row_in  [8];
    logic [DATA_W-1:0] col_out [8];

    logic       col_valid;
    logic       col_xfer;
    logic       release_bank;
    logic       wr_bank_free;
    logic       accept;
    logic       drop;

    logic       wr_bank_nxt;
    logic [2:0] wr_row_nxt;
    logic       rd_bank_nxt;
    logic [2:0] rd_col_nxt;
    logic [1:0] full_nxt;
    logic       overflow_nxt;

    always_comb begin
        row_in[0] = bus.i_data0;
        row_in[1] = bus.i_data1;
        row_in[2] = bus.i_data2;
        row_in[3] = bus.i_data3;
        row_in[4] = bus.i_data4;
        row_in[5] = bus.i_data5;
        row_in[6] = bus.i_data6;
        row_in[7] = bus.i_data7;
    end

    // Handshake decode; a bank being released this cycle can take row 0 of the next block.
    always_comb begin
        col_valid    = full[rd_bank];
        col_xfer     = col_valid && bus.i_ready;
        release_bank = col_xfer && (rd_col == 3'd7);
        wr_bank_free = !full[wr_bank] || (release_bank && (rd_bank == wr_bank));
        accept       = bus.i_valid && wr_bank_free;
        drop         = bus.i_valid && !wr_bank_free;
    end

    always_comb begin
        wr_bank_nxt  = wr_bank;
        wr_row_nxt   = wr_row;
        rd_bank_nxt  = rd_bank;
        rd_col_nxt   = rd_col;
        full_nxt     = full;
        overflow_nxt = overflow || drop;

        if (col_xfer) begin
            if (release_bank) begin
                full_nxt[rd_bank] = 1'b0;
                rd_bank_nxt       = !rd_bank;
                rd_col_nxt        = '0;
            end else begin
                rd_col_nxt = rd_col + 3'd1;
            end
        end

        if (accept) begin
            if (wr_row == 3'd7) begin
                full_nxt[wr_bank] = 1'b1;
                wr_bank_nxt       = !wr_bank;
                wr_row_nxt        = '0;
            end else begin
                wr_row_nxt = wr_row + 3'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_bank  <= 1'b0;
            wr_row   <= '0;
            rd_bank  <= 1'b0;
            rd_col   <= '0;
            full     <= '0;
            overflow <= 1'b0;
        end else begin
            wr_bank  <= wr_bank_nxt;
            wr_row   <= wr_row_nxt;
            rd_bank  <= rd_bank_nxt;
            rd_col   <= rd_col_nxt;
            full     <= full_nxt;
            overflow <= overflow_nxt;
        end
    end

    // Storage is deliberately unreset; the full flags gate every read of it.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            for (int unsigned c = 0; c < 8; c++) begin
                mem[wr_bank][wr_row][c[2:0]] <= row_in[c[2:0]];
            end
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < 8; k++) begin
            col_out[k[2:0]] = col_valid ? mem[rd_bank][k[2:0]][rd_col] : '0;
        end
    end

    always_comb begin
        bus.o_valid    = col_valid;
        bus.o_col_idx  = col_valid ? rd_col : '0;
        bus.o_last     = col_valid && (rd_col == 3'd7);
        bus.o_overflow = overflow;
        bus.o_data0    = col_out[0];
        bus.o_data1    = col_out[1];
        bus.o_data2    = col_out[2];
        bus.o_data3    = col_out[3];
        bus.o_data4    = col_out[4];
        bus.o_data5    = col_out[5];
        bus.o_data6    = col_out[6];
        bus.o_data7    = col_out[7];
    end

endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Randomised and directed bench for dct_transpose_buffer against a queue-based block model.
module tb_dct_transpose_buffer;
    localparam int DW = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dct_transpose_buffer_if #(.DATA_W(DW)) bus ();

    logic          vin = 1'b0;
    logic          rdy = 1'b0;
    logic [DW-1:0] din  [8];
    logic [DW-1:0] dout [8];

    assign bus.i_valid = vin;
    assign bus.i_ready = rdy;
    assign bus.i_data0 = din[0];
    assign bus.i_data1 = din[1];
    assign bus.i_data2 = din[2];
    assign bus.i_data3 = din[3];
    assign bus.i_data4 = din[4];
    assign bus.i_data5 = din[5];
    assign bus.i_data6 = din[6];
    assign bus.i_data7 = din[7];
    assign dout[0] = bus.o_data0;
    assign dout[1] = bus.o_data1;
    assign dout[2] = bus.o_data2;
    assign dout[3] = bus.o_data3;
    assign dout[4] = bus.o_data4;
    assign dout[5] = bus.o_data5;
    assign dout[6] = bus.o_data6;
    assign dout[7] = bus.o_data7;

    dct_transpose_buffer #(.DATA_W(DW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Model: completed blocks queued as 64 row-major values each, plus the block being filled.
    logic [DW-1:0] fq   [$];
    logic [DW-1:0] part [$];
    int            mcol    = 0;
    bit            movf    = 1'b0;
    bit            started = 1'b0;

    initial forever begin : model
        bit avail, rel, acc;
        @(posedge clk);
        if (rst) begin
            fq.delete();
            part.delete();
            mcol    = 0;
            movf    = 1'b0;
            started = 1'b1;
        end else begin
            avail = fq.size() >= 64;
            rel   = avail && rdy && (mcol == 7);
            acc   = vin && ((fq.size() < 128) || rel);
            if (vin && !acc) movf = 1'b1;
            if (rel) begin
                repeat (64) void'(fq.pop_front());
                mcol = 0;
            end else if (avail && rdy) begin
                mcol++;
            end
            if (acc) begin
                for (int k = 0; k < 8; k++) part.push_back(din[k]);
                if (part.size() == 64) begin
                    for (int k = 0; k < 64; k++) fq.push_back(part[k]);
                    part.delete();
                end
            end
        end
    end

    initial forever begin : compare
        bit            ev;
        bit            bad;
        logic [DW-1:0] ed [8];
        @(negedge clk);
        if (started) begin
            ev  = fq.size() >= 64;
            bad = 1'b0;
            for (int k = 0; k < 8; k++) begin
                ed[k] = ev ? fq[k*8 + mcol] : '0;
                if (dout[k] !== ed[k]) bad = 1'b1;
            end
            if (bus.o_valid !== ev) bad = 1'b1;
            if (bus.o_col_idx !== (ev ? 3'(mcol) : 3'd0)) bad = 1'b1;
            if (bus.o_last !== (ev && mcol == 7)) bad = 1'b1;
            if (bus.o_overflow !== movf) bad = 1'b1;
            checks++;
            if (bad) begin
                failures++;
                $display("FAIL cycle_compare t=%0t got v=%b col=%0d last=%b ovf=%b d0=%h d7=%h want v=%b col=%0d last=%b ovf=%b d0=%h d7=%h",
                         $time, bus.o_valid, bus.o_col_idx, bus.o_last, bus.o_overflow, dout[0], dout[7],
                         ev, ev ? mcol : 0, ev && mcol == 7, movf, ed[0], ed[7]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic send_block(input int base);
        for (int r = 0; r < 8; r++) begin
            vin = 1'b1;
            for (int c = 0; c < 8; c++) din[c] = DW'(base + r*8 + c);
            tick();
        end
        vin = 1'b0;
    endtask

    initial begin : stim
        int waited;
        for (int c = 0; c < 8; c++) din[c] = '0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_valid", bus.o_valid, 0);
        chk("reset_overflow", bus.o_overflow, 0);
        chk("reset_col_idx", bus.o_col_idx, 0);
        chk("reset_data0", dout[0], 0);

        // Single block, column 0 one cycle after the last row
        rdy = 1'b1;
        send_block(0);
        chk("single_valid", bus.o_valid, 1);
        chk("single_col0", bus.o_col_idx, 0);
        chk("single_c0_d5", dout[5], 40);
        repeat (7) tick();
        chk("single_last", bus.o_last, 1);
        chk("single_c7_d2", dout[2], 23);
        tick();
        chk("single_after", bus.o_valid, 0);

        // Back-to-back blocks
        send_block(0);
        send_block(100);
        chk("b2b_col_second_block", bus.o_col_idx, 0);
        chk("b2b_d1", dout[1], 100 + 8);
        repeat (12) tick();
        chk("b2b_no_overflow", bus.o_overflow, 0);

        // Stall at column 3
        send_block(200);
        waited = 0;
        while (!(bus.o_valid && bus.o_col_idx == 3) && waited < 20) begin
            tick();
            waited++;
        end
        chk("stall_reached_col3", int'(bus.o_valid && bus.o_col_idx == 3), 1);
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_hold_col", bus.o_col_idx, 3);
            chk("stall_hold_d4", dout[4], 200 + 32 + 3);
        end
        rdy = 1'b1;
        repeat (10) tick();

        // Overflow: 17 rows with the consumer stalled
        rdy = 1'b0;
        for (int r = 0; r < 17; r++) begin
            vin = 1'b1;
            for (int c = 0; c < 8; c++) din[c] = DW'(300 + r*8 + c);
            tick();
        end
        vin = 1'b0;
        chk("ovf_flag", bus.o_overflow, 1);
        chk("ovf_d1", dout[1], 308);
        rdy = 1'b1;
        repeat (20) tick();
        chk("ovf_sticky", bus.o_overflow, 1);

        // Sign extremes on a checkerboard
        for (int r = 0; r < 8; r++) begin
            vin = 1'b1;
            for (int c = 0; c < 8; c++) din[c] = ((r + c) % 2 == 1) ? 14'h3FFF : 14'h2000;
            tick();
        end
        vin = 1'b0;
        chk("sign_d0", dout[0], 14'h2000);
        chk("sign_d1", dout[1], 14'h3FFF);
        tick();
        chk("sign_c1_d0", dout[0], 14'h3FFF);
        repeat (10) tick();

        // Reset part-way into a block
        for (int r = 0; r < 5; r++) begin
            vin = 1'b1;
            for (int c = 0; c < 8; c++) din[c] = DW'(500 + r*8 + c);
            tick();
        end
        vin = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_overflow", bus.o_overflow, 0);
        chk("midrst_valid", bus.o_valid, 0);
        send_block(600);
        chk("midrst_col0", bus.o_col_idx, 0);
        chk("midrst_d3", dout[3], 600 + 24);
        repeat (10) tick();

        // Random traffic with back-pressure and drops
        for (int i = 0; i < 3000; i++) begin
            vin = ($urandom_range(0, 3) != 0);
            rdy = (i % 500 < 250) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            for (int c = 0; c < 8; c++) din[c] = DW'($urandom);
            tick();
        end
        vin = 1'b0;
        rdy = 1'b1;
        repeat (30) tick();
        chk("random_drained", bus.o_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
